// File: rtl/rect_fill_engine.sv
// rect_fill_engine: streams one framebuffer write per cycle, in raster order, for each accepted rectangle command.
module rect_fill_engine #(
  parameter int COORD_W = 8,
  parameter int COLOR_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               fb_ready,
  output logic               we,
  output logic [COORD_W-1:0] wx,
  output logic [COORD_W-1:0] wy,
  output logic [COLOR_W-1:0] wc,
  output logic               busy,
  output logic               done
);
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_next;
  logic [COORD_W-1:0] xmin, xmax, ymax, xlo, xhi, ylo, yhi;
  logic accept, adv, last;
  assign cmd_ready = state == IDLE;
  always_comb begin
    xlo = cmd_x0 < cmd_x1 ? cmd_x0 : cmd_x1;
    xhi = cmd_x0 < cmd_x1 ? cmd_x1 : cmd_x0;
    ylo = cmd_y0 < cmd_y1 ? cmd_y0 : cmd_y1;
    yhi = cmd_y0 < cmd_y1 ? cmd_y1 : cmd_y0;
    accept = cmd_valid && cmd_ready;
    adv = state == FILL && fb_ready;
    last = wx == xmax && wy == ymax;
    state_next = accept ? FILL : (adv && last) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xmin <= '0;
      xmax <= '0;
      ymax <= '0;
      wx   <= '0;
      wy   <= '0;
      wc   <= '0;
      we   <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= adv && last;
      busy <= state_next == FILL;
      if (accept) begin
        xmin <= xlo;
        xmax <= xhi;
        ymax <= yhi;
        wx   <= xlo;
        wy   <= ylo;
        wc   <= cmd_color;
        we   <= 1'b1;
      end else if (adv) begin
        // bounds are compared for equality, so a row ending at the top coordinate never wraps
        if (wx != xmax) wx <= wx + 1'b1;
        else if (wy != ymax) begin
          wx <= xmin;
          wy <= wy + 1'b1;
        end else we <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rect_fill_engine.sv
// tb_rect_fill_engine: directed and randomized rectangles checked against a raster-order pixel model.
module tb_rect_fill_engine;
  logic clk = 1'b0, rst = 1'b0, cmd_valid = 1'b0, fb_ready = 1'b0;
  logic [7:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic [11:0] cmd_color = '0;
  logic cmd_ready, we, busy, done;
  logic [7:0] wx, wy;
  logic [11:0] wc;
  int checks = 0, errors = 0;

  rect_fill_engine dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .fb_ready(fb_ready), .we(we), .wx(wx), .wy(wy),
    .wc(wc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode 0: random stalls at pct; mode 1: stall 3 cycles on pixel 1; keep_busy drives a stray command during the fill
  task automatic run_cmd(input int x0, input int y0, input int x1, input int y1, input int c,
                         input int pct, input int mode, input bit keep_busy, input bit strict);
    int xl, yl, w, h, n, k, cyc, st;
    xl = x0 < x1 ? x0 : x1;
    yl = y0 < y1 ? y0 : y1;
    w = (x0 < x1 ? x1 - x0 : x0 - x1) + 1;
    h = (y0 < y1 ? y1 - y0 : y0 - y1) + 1;
    n = w * h;
    chk("ready_before", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_x0 = 8'(x0); cmd_y0 = 8'(y0); cmd_x1 = 8'(x1); cmd_y1 = 8'(y1); cmd_color = 12'(c);
    @(negedge clk);
    cmd_valid = keep_busy;
    if (keep_busy) begin
      cmd_x0 = 8'($urandom_range(255)); cmd_y0 = 8'($urandom_range(255));
      cmd_x1 = cmd_x0; cmd_y1 = cmd_y0; cmd_color = 12'($urandom_range(4095));
    end
    k = 0; cyc = 0; st = 0;
    while (k < n && cyc < 2 * n + 200) begin
      chk("we", we, 1);
      chk("wx", wx, xl + k % w);
      chk("wy", wy, yl + k / w);
      if (strict || k == 0 || k == n - 1) begin
        chk("wc", wc, c);
        chk("busy", busy, 1);
        chk("ready_fill", cmd_ready, 0);
        chk("done_fill", done, 0);
      end
      fb_ready = mode == 1 ? !(k == 1 && st < 3) : $urandom_range(99) >= pct;
      if (fb_ready) k++; else st++;
      @(negedge clk);
      cyc++;
    end
    chk("count", k, n);
    chk("done", done, 1);
    chk("we_after", we, 0);
    chk("busy_after", busy, 0);
    chk("ready_after", cmd_ready, 1);
  endtask

  initial begin
    int a, b, c2, d;
    repeat (3) @(negedge clk);
    chk("rst_we", we, 0); chk("rst_done", done, 0); chk("rst_busy", busy, 0);
    chk("rst_wx", wx, 0); chk("rst_wy", wy, 0); chk("rst_wc", wc, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    run_cmd(10, 20, 10, 20, 'hABC, 0, 0, 0, 1);
    run_cmd(5, 3, 3, 2, 'h123, 0, 0, 0, 1);
    run_cmd(0, 7, 3, 7, 'h456, 0, 1, 0, 1);
    run_cmd(250, 100, 255, 96, 'h789, 0, 0, 1, 1);
    run_cmd(cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, 30, 0, 0, 1);
    for (int i = 0; i < 30; i++) begin
      a = $urandom_range(255); c2 = $urandom_range(255);
      b = a + $urandom_range(10) - 5; d = c2 + $urandom_range(6) - 3;
      b = b < 0 ? 0 : b > 255 ? 255 : b;
      d = d < 0 ? 0 : d > 255 ? 255 : d;
      run_cmd(a, c2, b, d, $urandom_range(4095), $urandom_range(50), 0, $urandom_range(1), 1);
      if ($urandom_range(1)) begin
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("idle_we", we, 0); chk("idle_done", done, 0); chk("idle_ready", cmd_ready, 1);
      end
    end
    run_cmd(0, 0, 255, 255, 'h000, 0, 0, 0, 0);
    cmd_valid = 1'b1;
    cmd_x0 = 8'd0; cmd_y0 = 8'd0; cmd_x1 = 8'd255; cmd_y1 = 8'd255; cmd_color = 12'hFFF;
    @(negedge clk);
    cmd_valid = 1'b0;
    fb_ready = 1'b1;
    repeat (99) @(negedge clk);
    chk("mid_wx", wx, 99); chk("mid_we", we, 1);
    #2 rst = 1'b0;
    #1 chk("async_we", we, 0); chk("async_busy", busy, 0); chk("async_wx", wx, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_we", we, 0); chk("post_done", done, 0); chk("post_ready", cmd_ready, 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rect_fill_engine.md
# rect_fill_engine

Rectangle fill engine that sits directly upstream of the 256x256 framebuffer's write port. It accepts one rectangle command at a time (two corners plus a 12-bit colour) over a valid/ready handshake. It then streams one framebuffer write per cycle in raster order (x fastest) until every pixel of the rectangle is written. It replaces the fixed power-on fill pattern with commanded drawing, and a full-screen rectangle serves as the clear operation.

## Interface

Parameters:
- COORD_W, 8, coordinate width; framebuffer is 2^COORD_W x 2^COORD_W.
- COLOR_W, 12, pixel width; {b[3:0], g[3:0], r[3:0]} packing, same as the framebuffer.

Ports:
- clk  in  1  pixel clock; the same clock as the framebuffer.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command; equals (state == IDLE).
- cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  COORD_W each  rectangle corners, inclusive, in any order.
- cmd_color  in  COLOR_W  fill colour.
- fb_ready  in  1  framebuffer accepts the write this cycle; low means stall.
- we  out  1  write strobe to the framebuffer.
- wx, wy  out  COORD_W  write coordinate.
- wc  out  COLOR_W  write colour.
- busy  out  1  high while in FILL.
- done  out  1  one-cycle pulse after the last pixel is accepted.

## Operation

- States: IDLE, FILL. Two states only; no other encodings are reachable.
- **Accept.** A command is accepted at a rising edge where cmd_valid && cmd_ready.
- **Latching on accept.** At that edge the engine latches:
  - xmin = min(x0,x1), xmax = max(x0,x1), ymin = min(y0,y1), ymax = max(y0,y1) (unsigned compare);
  - colour.
- **Outputs loaded on accept.** The same edge loads wx = xmin, wy = ymin, wc = colour, we = 1, and moves to FILL.
- **Advance.** In FILL, on each edge with fb_ready = 1 (the write is accepted):
  - if wx != xmax: wx <= wx + 1;
  - else if wy != ymax: wx <= xmin, wy <= wy + 1;
  - else (last pixel): we <= 0, state <= IDLE, done <= 1.
- **Stall.** In FILL with fb_ready = 0, we, wx, wy and wc hold their values unchanged.
- **Ignored commands.** cmd_valid is ignored while in FILL, because cmd_ready = 0. There is no queueing.
- **Arithmetic.** All comparisons are equality against the latched bounds, so coordinates never wrap past 2^COORD_W − 1. For example, xmax = 255 terminates the row correctly with no overflow.
- **Pixel count.** Exactly (xmax−xmin+1)·(ymax−ymin+1) accepted writes per command. The maximum is 65536 with the default parameters.
- **Degenerate rectangles.** x0 == x1 and/or y0 == y1 is legal; a single-pixel rectangle produces one write.
- **Reset.** While rst = 0, asynchronously and regardless of state:
  - state = IDLE;
  - we = 0, done = 0, busy = 0;
  - wx = wy = 0, wc = 0;
  - cmd_ready = 1 once rst deasserts.
- **Reset mid-fill.** A partially drawn rectangle is abandoned; no further writes occur.

## Timing

- **Accept to first write:** 0 extra cycles. we is high in the cycle immediately after the accept edge, with wx/wy equal to the first pixel.
- **Throughput:** 1 pixel/cycle when fb_ready is held high. An N-pixel rectangle occupies FILL for exactly N cycles plus one cycle per stalled (fb_ready = 0) cycle.
- **Completion:** done is high for exactly one cycle, starting the cycle after the last accepted write.
  - In that same cycle: we = 0, busy = 0 and cmd_ready = 1.
  - A new command presented in that cycle is accepted at the next edge.
  - Back-to-back rectangles therefore have a one-cycle gap with we = 0.
- **Registered outputs:** we, wx, wy, wc, done and busy come straight from registers. cmd_ready is decoded from the state register only, with no combinational path from cmd_valid.
- **fb_ready timing:** fb_ready is sampled only at rising edges while we = 1; its value while we = 0 is irrelevant.

## Test plan

- **Single pixel.** Command (x0=10, y0=20, x1=10, y1=20, color=0xABC) with fb_ready = 1.
  - Exactly one cycle with we = 1, wx = 10, wy = 20, wc = 0xABC.
  - done pulses on the next cycle and cmd_ready returns to 1.
- **Swapped corners.** Command (x0=5, y0=3, x1=3, y1=2).
  - 6 writes in the order (3,2),(4,2),(5,2),(3,3),(4,3),(5,3).
  - we is high for 6 consecutive cycles, then done.
- **Full screen.** Command (0,0,255,255, color=0x000).
  - 65536 writes with no duplicates and no gaps.
  - The last write is (255,255); done follows on the 65537th cycle after accept.
- **Backpressure.** On a 4x1 rectangle, drive fb_ready = 0 for 3 cycles during the second pixel.
  - wx, wy and wc are held through the stall.
  - 4 accepted writes in total; completion is 3 cycles later than the unstalled case.
- **Command while busy.** Assert cmd_valid with new coordinates during a fill.
  - The command is ignored and the current fill is unchanged.
  - A command still asserted in the done cycle is accepted at the next edge, and its first write appears on the following cycle.
- **Reset mid-fill.** Pull rst low asynchronously, between clock edges, during the 100th pixel of a full-screen fill.
  - we = 0 immediately.
  - After release: IDLE, cmd_ready = 1, no done pulse, no further writes.
